// File: rtl/addsub_pkg.sv
// Shared types and sizing helpers for the digit-serial adder-subtractor.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned num_digits(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

    // Counter must hold 0..n-1 and never collapse to zero width.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/addsub_serial_if.sv
// Operand/result handshake bundle for addsub_serial.
interface addsub_serial_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A_in;
    logic [WIDTH-1:0] B_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S_out;
    logic             overflow;
    logic             neg;
    logic             zero;
    logic             carry;

    modport master (
        output in_valid, A_in, B_in, sub, out_ready,
        input  in_ready, out_valid, S_out, overflow, neg, zero, carry
    );

    modport slave (
        input  in_valid, A_in, B_in, sub, out_ready,
        output in_ready, out_valid, S_out, overflow, neg, zero, carry
    );
endinterface

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple-carry adder slice.
module addsub_digit #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);
    logic [DIGIT:0] c;

    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < int'(DIGIT); i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[DIGIT];
    end
endmodule

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder-subtractor with valid/ready on both sides.
// Optional result saturation on signed overflow: define ADDSUB_SAT_EN.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input logic            clk,
    input logic            rst,
    addsub_serial_if.slave bus
);
    localparam int unsigned N   = num_digits(WIDTH, DIGIT);
    localparam int unsigned CW  = cnt_width(N);
    localparam int unsigned MSB = WIDTH - 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("addsub_serial: WIDTH must be >= 2 and a multiple of DIGIT >= 1");
        end
    endgenerate

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic             c_q;
    logic [CW-1:0]    cnt_q;
    logic             a_msb_q, b_msb_q;

    logic [WIDTH-1:0] beff_c;
    logic [DIGIT-1:0] s_dig_c;
    logic             cout_c;
    logic             last_c;
    logic [WIDTH+DIGIT-1:0] cat_c;
    logic [WIDTH-1:0] res_next_c;
    logic             ov_c;
    logic [WIDTH-1:0] s_fin_c;

    assign beff_c = bus.sub ? ~bus.B_in : bus.B_in;
    assign last_c = (cnt_q == CW'(N - 1));

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .a    (a_q[DIGIT-1:0]),
        .b    (b_q[DIGIT-1:0]),
        .cin  (c_q),
        .s    (s_dig_c),
        .cout (cout_c)
    );

    // New digit enters at the top; after N digits the result is right-aligned.
    assign cat_c      = {s_dig_c, res_q};
    assign res_next_c = cat_c[WIDTH+DIGIT-1:DIGIT];
    assign ov_c       = (a_msb_q == b_msb_q) && (s_dig_c[DIGIT-1] != a_msb_q);

`ifdef ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    assign s_fin_c = ov_c ? (a_msb_q ? SAT_MIN : SAT_MAX) : res_next_c;
`else
    assign s_fin_c = res_next_c;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = RUN;
            RUN:     if (last_c)        state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
        end else begin
            bus.in_ready  <= (state_d == IDLE);
            bus.out_valid <= (state_d == DONE);
        end
    end

    // Operand shift registers, carry, counter and result/flag capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            c_q          <= 1'b0;
            cnt_q        <= '0;
            a_msb_q      <= 1'b0;
            b_msb_q      <= 1'b0;
            bus.S_out    <= '0;
            bus.overflow <= 1'b0;
            bus.neg      <= 1'b0;
            bus.zero     <= 1'b0;
            bus.carry    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.A_in;
                        b_q     <= beff_c;
                        c_q     <= bus.sub;
                        cnt_q   <= '0;
                        a_msb_q <= bus.A_in[MSB];
                        b_msb_q <= beff_c[MSB];
                    end
                end
                RUN: begin
                    a_q   <= a_q >> DIGIT;
                    b_q   <= b_q >> DIGIT;
                    c_q   <= cout_c;
                    res_q <= res_next_c;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_c) begin
                        bus.S_out    <= s_fin_c;
                        bus.overflow <= ov_c;
                        bus.neg      <= s_fin_c[MSB];
                        bus.zero     <= (s_fin_c == '0);
                        bus.carry    <= cout_c;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
